fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined core. It owns the PC register, drives instruction-cache requests, and loads the IF/ID latch whose `ifid_instr` feeds the decode-stage control unit. It also handles stalls from the hazard logic, redirects from branch/jump resolution, and the halt stop. An optional one-entry prefetch buffer keeps fetching while decode is stalled.

---
 rtl/pipeline_types_pkg.sv | 27 ++
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_prefetch_buf.sv | 30 +++
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline_types_pkg.sv
// Shared pipeline types for the fetch stage: FSM states, IF/ID latch
// layout and the canonical nop encoding.
package pipeline_types_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
    } ifid_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // An empty IF/ID slot: nop instruction, zero npc, not valid.
    function automatic ifid_t ifid_bubble();
        ifid_t b;
        b.instr = NOP_INSTR;
        b.npc   = 32'h0000_0000;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-cache request/response bundle between the fetch stage
// (master) and the icache (slave).
interface fetch_stage_if;
    logic        iREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;

    modport master (
        output iREN,
        output imemaddr,
        input  ihit,
        input  imemload
    );

    modport slave (
        input  iREN,
        input  imemaddr,
        output ihit,
        output imemload
    );
endinterface

// File: rtl/fetch_prefetch_buf.sv
// One-entry prefetch buffer holding a fetched {instr, npc, valid} while
// decode is stalled. Clear and drain both empty it; load fills it.
import pipeline_types_pkg::*;

module fetch_prefetch_buf (
    input  logic  clk,
    input  logic  srst,
    input  logic  load,
    input  logic  drain,
    input  logic  clear,
    input  ifid_t load_data,
    output ifid_t data,
    output logic  valid
);
    ifid_t entry_reg;

    // Entry register: clears dominate, then capture, then drain.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            entry_reg <= ifid_bubble();
        end else if (load) begin
            entry_reg <= load_data;
        end else if (drain) begin
            entry_reg <= ifid_bubble();
        end
    end

    assign data  = entry_reg;
    assign valid = entry_reg.valid;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, icache request, IF/ID latch,
// stall/redirect/halt handling.
// Optional feature macro: FETCH_PREFETCH_EN adds a one-entry prefetch
// buffer that keeps fetching while decode is stalled.
import pipeline_types_pkg::*;

module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               RST,
    fetch_stage_if.master      imem,
    input  logic               stall_if,
    input  logic               redirect,
    input  logic [31:0]        redirect_addr,
    input  logic               halt_dec,
    output logic [31:0]        ifid_instr,
    output logic [31:0]        ifid_npc,
    output logic               ifid_valid,
    output logic               halted
);
    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    ifid_t        ifid_reg, ifid_next;
    logic [31:0]  pc_plus4;
    logic         iren;
    logic         buf_valid;
    logic         buf_load;
    logic         buf_drain;
    logic         buf_clear;
    ifid_t        fetched;

    assign pc_plus4 = pc_reg + 32'd4;

    assign fetched.instr = imem.imemload;
    assign fetched.npc   = pc_plus4;
    assign fetched.valid = 1'b1;

`ifdef FETCH_PREFETCH_EN
    ifid_t buf_data;

    fetch_prefetch_buf u_prefetch_buf (
        .clk       (CLK),
        .srst      (RST),
        .load      (buf_load),
        .drain     (buf_drain),
        .clear     (buf_clear),
        .load_data (fetched),
        .data      (buf_data),
        .valid     (buf_valid)
    );

    // Keep requesting during a stall until the buffer is full.
    assign iren = (state_reg == RUN) && !RST && !buf_valid;
`else
    assign buf_valid = 1'b0;

    // No place to park a fetch, so a stall suppresses the request.
    assign iren = (state_reg == RUN) && !RST && !stall_if;
`endif

    assign imem.iREN     = iren;
    assign imem.imemaddr = pc_reg;

    // State, PC and IF/ID registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= RUN;
            pc_reg    <= PC_INIT;
            ifid_reg  <= ifid_bubble();
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ifid_reg  <= ifid_next;
        end
    end

    // Next-state logic in descending priority: redirect, halt, stall,
    // buffer drain, normal fetch, bubble.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ifid_next  = ifid_reg;
        buf_load   = 1'b0;
        buf_drain  = 1'b0;
        buf_clear  = 1'b0;
        if (state_reg == HALTED) begin
            ifid_next = ifid_bubble();
        end else if (redirect) begin
            pc_next   = redirect_addr & 32'hFFFF_FFFC;
            ifid_next = ifid_bubble();
            buf_clear = 1'b1;
        end else if (halt_dec) begin
            state_next = HALTED;
            ifid_next  = ifid_bubble();
            buf_clear  = 1'b1;
        end else if (stall_if) begin
            // IF/ID holds; a prefetch may still park one word.
            if (imem.ihit && iren) begin
                buf_load = 1'b1;
                pc_next  = pc_plus4;
            end
        end else if (buf_valid) begin
`ifdef FETCH_PREFETCH_EN
            ifid_next = buf_data;
`endif
            buf_drain = 1'b1;
        end else if (imem.ihit && iren) begin
            ifid_next = fetched;
            pc_next   = pc_plus4;
        end else begin
            ifid_next = ifid_bubble();
        end
    end

    assign ifid_instr = ifid_reg.instr;
    assign ifid_npc   = ifid_reg.npc;
    assign ifid_valid = ifid_reg.valid;
    assign halted     = (state_reg == HALTED);
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed test-plan sequences followed
// by randomized traffic, compared against a cycle-level reference model.
module tb_fetch_stage;
    localparam logic [31:0] PC_INIT = 32'h0000_0000;
`ifdef FETCH_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_if;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        halt_dec;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;
    logic        halted;

    fetch_stage_if imem_if ();

    fetch_stage #(.PC_INIT(PC_INIT)) dut (
        .CLK           (clk),
        .RST           (rst),
        .imem          (imem_if),
        .stall_if      (stall_if),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt_dec      (halt_dec),
        .ifid_instr    (ifid_instr),
        .ifid_npc      (ifid_npc),
        .ifid_valid    (ifid_valid),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        iren;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr, m_npc;
    logic        m_valid, m_halted;
    logic        m_bvalid;
    logic [31:0] m_binstr, m_bnpc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares outputs against the oldest expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("iREN", {31'b0, imem_if.iREN}, {31'b0, e.iren});
                check("imemaddr", imem_if.imemaddr, e.addr);
                check("ifid_instr", ifid_instr, e.instr);
                check("ifid_npc", ifid_npc, e.npc);
                check("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
                check("halted", {31'b0, halted}, {31'b0, e.halted});
            end
        end
    end

    // Drive one cycle, record the expected outputs, advance the model.
    task automatic cyc(input logic r, input logic hit, input logic [31:0] word,
                       input logic st, input logic rd, input logic [31:0] ra,
                       input logic hd);
        exp_t  e;
        logic  req;
        @(negedge clk);
        rst = r; imem_if.ihit = hit; imem_if.imemload = word;
        stall_if = st; redirect = rd; redirect_addr = ra; halt_dec = hd;

        req = !r && !m_halted && !m_bvalid && (PF ? 1'b1 : !st);
        e.iren = req; e.addr = m_pc; e.instr = m_instr; e.npc = m_npc;
        e.valid = m_valid; e.halted = m_halted;
        exp_q.push_back(e);
        $display("cyc rst=%0b hit=%0b st=%0b rd=%0b ra=%h hd=%0b | exp iren=%0b addr=%h instr=%h npc=%h v=%0b h=%0b",
                 r, hit, st, rd, ra, hd, e.iren, e.addr, e.instr, e.npc, e.valid, e.halted);

        if (r) begin
            m_pc = PC_INIT; m_halted = 0; m_bvalid = 0;
            m_instr = 0; m_npc = 0; m_valid = 0;
        end else if (m_halted) begin
            m_instr = 0; m_npc = 0; m_valid = 0;
        end else if (rd) begin
            m_pc = {ra[31:2], 2'b00}; m_bvalid = 0;
            m_instr = 0; m_npc = 0; m_valid = 0;
        end else if (hd) begin
            m_halted = 1; m_bvalid = 0;
            m_instr = 0; m_npc = 0; m_valid = 0;
        end else if (st) begin
            if (PF && hit && req) begin
                m_bvalid = 1; m_binstr = word; m_bnpc = m_pc + 32'd4;
                m_pc = m_pc + 32'd4;
            end
        end else if (m_bvalid) begin
            m_instr = m_binstr; m_npc = m_bnpc; m_valid = 1; m_bvalid = 0;
        end else if (hit && req) begin
            m_instr = word; m_npc = m_pc + 32'd4; m_valid = 1;
            m_pc = m_pc + 32'd4;
        end else begin
            m_instr = 0; m_npc = 0; m_valid = 0;
        end
    endtask

    initial begin
        logic [31:0] ra;
        rst = 1; imem_if.ihit = 0; imem_if.imemload = 0;
        stall_if = 0; redirect = 0; redirect_addr = 0; halt_dec = 0;
        m_pc = 32'hDEAD_BEEF; m_instr = 32'hx; m_npc = 32'hx; m_valid = 1'bx;
        m_halted = 1'bx; m_bvalid = 0; m_binstr = 0; m_bnpc = 0;
        @(posedge clk);
        // First recorded reset cycle: state already reset by the edge above.
        m_pc = PC_INIT; m_instr = 0; m_npc = 0; m_valid = 0; m_halted = 0;

        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 32'h1234_5678, 0, 0, 0, 0);
        // Continuous fetch
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'h2001_0005, 0, 0, 0, 0);
        // Misses at pc 0x10
        cyc(0, 1, 32'hAAAA_0001, 0, 1, 32'h10, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h1111_2222, 0, 0, 0, 0);
        // Redirect coincident with ihit, bits [1:0] ignored
        cyc(0, 1, 32'hBAD0_BAD0, 0, 1, 32'h103, 0);
        cyc(0, 1, 32'h3333_4444, 0, 0, 0, 0);
        // Stall for 4 cycles with icache hitting, then release
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'h5000_0000 + i, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h6000_0000 + i, 0, 0, 0, 0);
        // Wrap at the top of the address space
        cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
        cyc(0, 1, 32'h7777_7777, 0, 0, 0, 0);
        cyc(0, 1, 32'h8888_8888, 0, 0, 0, 0);
        // Halt coincident with redirect does not halt
        cyc(0, 1, 32'h9, 0, 1, 32'h200, 1);
        cyc(0, 1, 32'hA, 0, 0, 0, 0);
        // Real halt; later redirect and stall are ignored
        cyc(0, 1, 32'hB, 0, 0, 0, 1);
        cyc(0, 1, 32'hC, 0, 1, 32'h400, 0);
        cyc(0, 1, 32'hD, 1, 0, 0, 0);
        cyc(0, 1, 32'hE, 0, 0, 0, 0);
        cyc(1, 1, 32'hF, 0, 0, 0, 0);
        cyc(0, 1, 32'h10, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
            cyc($urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 70,
                $urandom,
                $urandom_range(0, 99) < 25,
                $urandom_range(0, 99) < 5,
                ra,
                $urandom_range(0, 99) < 2);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #5;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
